// File: rtl/riscv_pkg.sv
// Shared opcodes, ALU operations and FSM states for the multicycle RV32I core.
package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;

  // alt is instr bit 30; it selects SUB only for register-register ops
  function automatic alu_op_t alu_op_from_f3(logic [2:0] f3, logic alt, logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_if.sv
// Instruction fetch bus between the core FSM and the instruction memory.
interface riscv_if;
  logic        req;
  logic [29:0] addr;
  logic        valid;
  logic [31:0] data;

  modport master (output req, addr, input valid, data);
  modport slave  (input req, addr, output valid, data);
endinterface

// File: rtl/riscv_imem.sv
// Fixed-latency instruction ROM; contents are loaded hierarchically and never reset.
module riscv_imem #(
  parameter int IMEM_WORDS   = 1024,
  parameter int IMEM_LATENCY = 5
) (
  input logic   clock,
  input logic   reset,
  riscv_if.slave bus
);

  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int CW = $clog2(IMEM_LATENCY + 1);

  logic [31:0]   IMem [0:IMEM_WORDS-1];
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] word;

  assign word = AW'(bus.addr % 30'(IMEM_WORDS));

  // cnt is a down-counter; the response fires on its terminal count of 1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      bus.valid <= 1'b0;
      bus.data  <= '0;
    end else begin
      bus.valid <= 1'b0;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          bus.valid <= 1'b1;
          bus.data  <= IMem[addr_q];
        end
      end else if (bus.req && !bus.valid) begin
        addr_q <= word;
        cnt    <= CW'(IMEM_LATENCY);
      end
    end
  end

endmodule

// File: rtl/riscv_cpu.sv
// Multicycle RV32I integer core: fetch from imem, execute, write back.
//   state | meaning
//   FETCH | request outstanding, wait for iMem_valid, latch IR
//   EXEC  | decode, ALU / branch compare, compute next pc
//   WB    | write rd, commit pc, issue next fetch request
module riscv_cpu
  import riscv_pkg::*;
#(
  parameter int          IMEM_WORDS   = 1024,
  parameter int          IMEM_LATENCY = 5,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input logic clock,
  input logic reset
);

  riscv_if imem_bus ();

  riscv_imem #(.IMEM_WORDS(IMEM_WORDS), .IMEM_LATENCY(IMEM_LATENCY)) imem (
    .clock (clock),
    .reset (reset),
    .bus   (imem_bus.slave)
  );

  logic        iMem_valid;
  logic [31:0] iMem_data;
  assign iMem_valid = imem_bus.valid;
  assign iMem_data  = imem_bus.data;

  state_t      state;
  logic [31:0] pc, ir, pc_next_q, result_q;
  logic        wr_en_q, req_q;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, imm_b, imm_j, rs1_val, rs2_val;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign f3      = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_u   = {ir[31:12], 12'b0};
  assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  alu_op_t     alu_op;
  logic [31:0] op_a, op_b, target, pc_next;
  logic        wr_en, taken;

  always_comb begin
    alu_op = ALU_ADD;
    op_a   = rs1_val;
    op_b   = imm_i;
    wr_en  = 1'b0;
    taken  = 1'b0;
    target = pc + 32'd4;
    case (opcode)
      OP_IMM: begin
        wr_en  = 1'b1;
        alu_op = alu_op_from_f3(f3, ir[30], 1'b0);
      end
      OP: begin
        wr_en  = 1'b1;
        op_b   = rs2_val;
        alu_op = alu_op_from_f3(f3, ir[30], 1'b1);
      end
      LUI: begin
        wr_en = 1'b1;
        op_a  = '0;
        op_b  = imm_u;
      end
      AUIPC: begin
        wr_en = 1'b1;
        op_a  = pc;
        op_b  = imm_u;
      end
      JAL: begin
        wr_en  = 1'b1;
        op_a   = pc;
        op_b   = 32'd4;
        target = pc + imm_j;
      end
      JALR: begin
        wr_en  = 1'b1;
        op_a   = pc;
        op_b   = 32'd4;
        target = (rs1_val + imm_i) & ~32'd1;
      end
      BRANCH: begin
        case (f3)
          3'b000:  taken = rs1_val == rs2_val;
          3'b001:  taken = rs1_val != rs2_val;
          3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
          3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
          3'b110:  taken = rs1_val <  rs2_val;
          3'b111:  taken = rs1_val >= rs2_val;
          default: taken = 1'b0;
        endcase
        if (taken) target = pc + imm_b;
      end
      default: ;
    endcase
    pc_next = target & ~32'd3;
  end

  // During WB the next pc is already known, so the fetch is accepted on the WB edge
  assign imem_bus.req  = req_q;
  assign imem_bus.addr = (state == WB) ? pc_next_q[31:2] : pc[31:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pc_next_q <= RESET_PC;
      ir        <= NOP;
      result_q  <= '0;
      wr_en_q   <= 1'b0;
      req_q     <= 1'b1;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (iMem_valid) begin
          ir    <= iMem_data;
          req_q <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          result_q  <= alu(alu_op, op_a, op_b);
          wr_en_q   <= wr_en;
          pc_next_q <= pc_next;
          req_q     <= 1'b1;
          state     <= WB;
        end
        WB: begin
          pc <= pc_next_q;
          if (wr_en_q && rd != 5'd0) regs[rd] <= result_q;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed bench for riscv_cpu: fetch latency, ALU table, control flow, async reset, pc wrap.
module tb_riscv_cpu;
  import riscv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  riscv_cpu dut (.clock(clock), .reset(reset));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs1, int rs2, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_retire(string name);
    bit ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (dut.state == WB) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: retire timeout got none expected WB", name);
    end
  endtask

  task automatic hold_reset_and_clear();
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) dut.imem.IMem[i] = NOP;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{enc_i(-1, 0, 0, 1, 'h13),          1,  32'hFFFFFFFF};
    vecs[1]  = '{enc_i(28, 1, 5, 2, 'h13),          2,  32'h0000000F};
    vecs[2]  = '{enc_r('h20, 1, 2, 0, 3, 'h33),     3,  32'h00000010};
    vecs[3]  = '{enc_r(0, 2, 1, 2, 4, 'h33),        4,  32'h00000001};
    vecs[4]  = '{enc_r(0, 2, 1, 3, 5, 'h33),        5,  32'h00000000};
    vecs[5]  = '{enc_u('h12345, 6, 'h37),           6,  32'h12345000};
    vecs[6]  = '{enc_u(1, 7, 'h17),                 7,  32'h00001018};
    vecs[7]  = '{enc_i('h404, 1, 5, 8, 'h13),       8,  32'hFFFFFFFF};
    vecs[8]  = '{enc_i('hF0, 2, 4, 9, 'h13),        9,  32'h000000FF};
    vecs[9]  = '{enc_r(0, 2, 2, 1, 10, 'h33),       10, 32'h00078000};
    vecs[10] = '{enc_r(0, 2, 3, 6, 11, 'h33),       11, 32'h0000001F};
    vecs[11] = '{enc_r(0, 3, 1, 7, 12, 'h33),       12, 32'h00000010};
    vecs[12] = '{enc_i(5, 0, 0, 0, 'h13),           0,  32'h00000000};
    vecs[13] = '{enc_r(0, 3, 6, 5, 13, 'h33),       13, 32'h00001234};
    vecs[14] = '{enc_i(33, 0, 0, 15, 'h13),         15, 32'h00000021};
    vecs[15] = '{enc_r(0, 15, 2, 1, 16, 'h33),      16, 32'h0000001E};
    vecs[16] = '{enc_i(0, 1, 2, 17, 'h13),          17, 32'h00000001};
    vecs[17] = '{enc_i(-1, 2, 3, 18, 'h13),         18, 32'h00000001};
    vecs[18] = '{enc_i('h7FF, 1, 7, 19, 'h13),      19, 32'h000007FF};
    vecs[19] = '{enc_r(0, 3, 1, 0, 20, 'h33),       20, 32'h0000000F};
    vecs[20] = '{enc_i(0, 0, 2, 21, 'h03),          21, 32'h00000000};

    // Reset state and first-fetch latency
    #3;
    hold_reset_and_clear();
    dut.imem.IMem[0] = 32'h00500093;
    #1;
    chk("rst_pc",    dut.pc, 32'h0);
    chk("rst_valid", 32'(dut.iMem_valid), 32'h0);
    chk("rst_data",  dut.iMem_data, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(FETCH));
    release_reset();
    for (int e = 1; e <= 14; e++) begin
      @(posedge clock);
      #1;
      if (e == 6) begin
        chk("lat_first_valid", 32'(dut.iMem_valid), 32'h1);
        chk("lat_first_data",  dut.iMem_data, 32'h00500093);
      end else if (e == 14) begin
        chk("lat_next_valid", 32'(dut.iMem_valid), 32'h1);
        chk("lat_next_data",  dut.iMem_data, NOP);
      end else begin
        chk($sformatf("lat_idle_e%0d", e), 32'(dut.iMem_valid), 32'h0);
      end
      if (e == 8) chk("x1_before_wb", dut.regs[1], 32'h0);
      if (e == 9) begin
        chk("x1_after_wb", dut.regs[1], 32'h5);
        chk("pc_after_wb", dut.pc, 32'h4);
      end
    end

    // ALU / immediate table, one retire per vector
    hold_reset_and_clear();
    for (int i = 0; i < 21; i++) dut.imem.IMem[i] = vecs[i].instr;
    release_reset();
    for (int i = 0; i < 21; i++) begin
      wait_retire($sformatf("alu%0d", i));
      chk($sformatf("alu%0d_reg", i), dut.regs[vecs[i].rd], vecs[i].exp);
      chk($sformatf("alu%0d_pc", i), dut.pc, 32'(4 * (i + 1)));
    end

    // Async reset clears the register file without a clock edge
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    begin
      logic [31:0] any_reg = '0;
      for (int i = 0; i < 32; i++) any_reg |= dut.regs[i];
      chk("rst_regs_zero", any_reg, 32'h0);
    end
    chk("rst_pc_again",   dut.pc, 32'h0);
    chk("rst_data_again", dut.iMem_data, 32'h0);

    // Control flow: beq taken, jal link, bne/blt not taken, jalr return with bit 0 cleared
    hold_reset_and_clear();
    dut.imem.IMem[0] = enc_b(8, 0, 0, 0);
    dut.imem.IMem[1] = enc_i(1, 0, 0, 2, 'h13);
    dut.imem.IMem[2] = enc_j(8, 1);
    dut.imem.IMem[3] = enc_i(9, 0, 0, 3, 'h13);
    dut.imem.IMem[4] = enc_b(64, 0, 0, 1);
    dut.imem.IMem[5] = enc_b(64, 1, 0, 4);
    dut.imem.IMem[6] = enc_i(1, 1, 0, 0, 'h67);
    release_reset();
    wait_retire("cf1"); chk("cf_beq_pc", dut.pc, 32'd8);
    wait_retire("cf2"); chk("cf_jal_pc", dut.pc, 32'd16); chk("cf_jal_link", dut.regs[1], 32'd12);
    wait_retire("cf3"); chk("cf_bne_pc", dut.pc, 32'd20);
    wait_retire("cf4"); chk("cf_blt_pc", dut.pc, 32'd24);
    wait_retire("cf5"); chk("cf_jalr_pc", dut.pc, 32'd12); chk("cf_x0", dut.regs[0], 32'h0);
    wait_retire("cf6");
    chk("cf_ret_pc", dut.pc, 32'd16);
    chk("cf_x3", dut.regs[3], 32'd9);
    chk("cf_skipped_x2", dut.regs[2], 32'h0);

    // Reset two cycles after a fetch was accepted, then again while valid is high
    hold_reset_and_clear();
    dut.imem.IMem[0] = 32'h00500093;
    release_reset();
    wait_retire("mid_retire");
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_pc",    dut.pc, 32'h0);
    chk("mid_cnt",   32'(dut.imem.cnt), 32'h0);
    chk("mid_valid", 32'(dut.iMem_valid), 32'h0);
    release_reset();
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock);
      #1;
      if (e == 5) chk("refetch_e5_valid", 32'(dut.iMem_valid), 32'h0);
    end
    chk("refetch_valid", 32'(dut.iMem_valid), 32'h1);
    chk("refetch_data",  dut.iMem_data, 32'h00500093);
    #2;
    reset = 1'b0;
    #1;
    chk("valid_abort", 32'(dut.iMem_valid), 32'h0);

    // pc wraps past the last word back to IMem[0]
    hold_reset_and_clear();
    dut.imem.IMem[0]    = enc_j(4092, 0);
    dut.imem.IMem[1023] = enc_i(7, 0, 0, 6, 'h13);
    release_reset();
    wait_retire("wrap1"); chk("wrap_jump_pc", dut.pc, 32'd4092);
    wait_retire("wrap2"); chk("wrap_x6", dut.regs[6], 32'd7); chk("wrap_pc", dut.pc, 32'd4096);
    begin
      bit got = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        if (dut.iMem_valid) begin got = 1'b1; break; end
      end
      chk("wrap_valid", 32'(got), 32'h1);
      chk("wrap_data", dut.iMem_data, enc_j(4092, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
